// File: rtl/periferico_temporizador.sv
// periferico_temporizador: memory-mapped 8-bit timer with prescaler, compare flag and interrupt.
// Optional macro TIMER_PWM_EN adds a registered PWM output and the CTRL[3] PWM_INV bit.
module periferico_temporizador #(
  parameter logic [7:0] BASE_ADDR   = 8'hF0,
  parameter logic [7:0] PRESC_RESET = 8'h00
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Direccion_Dato,
  input  logic [7:0] Entrada_Datos,
  input  logic       RW,
  output logic [7:0] Datos_Salida,
  output logic       Irq,
  output logic       Pwm
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       auto_q, auto_d;
  logic       ie_q, ie_d;
  logic       flag_q, flag_d;
  logic       flag_set_s;
  logic       inv_s;
  logic [7:0] presc_q, presc_d;
  logic [7:0] cmp_q, cmp_d;
  logic [7:0] cnt_q, cnt_d, cnt_seq_s;
  logic [7:0] pre_q, pre_d;
  logic [7:0] dout_q, dout_d;
  logic       irq_q, irq_d;
  logic       pwm_q, pwm_d;

  logic       sel_s;
  logic [1:0] off_s;
  logic       wr_ctrl_s, wr_presc_s, wr_cmp_s, wr_cnt_s;
  logic       running_s, tick_s;
  logic [7:0] ctrl_rd_s;

  assign sel_s      = (Direccion_Dato[7:2] == BASE_ADDR[7:2]);
  assign off_s      = Direccion_Dato[1:0];
  assign wr_ctrl_s  = sel_s & RW & (off_s == 2'd0);
  assign wr_presc_s = sel_s & RW & (off_s == 2'd1);
  assign wr_cmp_s   = sel_s & RW & (off_s == 2'd2);
  assign wr_cnt_s   = sel_s & RW & (off_s == 2'd3);

  // EN is not stored separately: it reads back as "currently running".
  assign running_s  = (state_q == S_RUN);
  assign tick_s     = running_s & (pre_q == presc_q);
  assign ctrl_rd_s  = {flag_q, 3'b000, inv_s, ie_q, auto_q, running_s};

  // Next state, prescaler and counter sequencing; bus writes to CNT override below.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_seq_s  = cnt_q;
    flag_set_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (wr_ctrl_s && Entrada_Datos[0]) begin
          state_d = S_RUN;
          pre_d   = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (wr_ctrl_s && !Entrada_Datos[0]) begin
          state_d = S_IDLE;
          pre_d   = 8'd0;
        end else if (tick_s) begin
          pre_d = 8'd0;
          if (cnt_q == cmp_q) begin
            flag_set_s = 1'b1;
            if (auto_q) begin
              cnt_seq_s = 8'd0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_seq_s = cnt_q + 8'd1;
          end
        end else begin
          pre_d = pre_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pre_d   = 8'd0;
      end
    endcase
  end

  // A hardware set beats a simultaneous write-1-to-clear.
  assign flag_d  = flag_set_s | (flag_q & ~(wr_ctrl_s & Entrada_Datos[7]));
  assign auto_d  = wr_ctrl_s  ? Entrada_Datos[1] : auto_q;
  assign ie_d    = wr_ctrl_s  ? Entrada_Datos[2] : ie_q;
  assign presc_d = wr_presc_s ? Entrada_Datos    : presc_q;
  assign cmp_d   = wr_cmp_s   ? Entrada_Datos    : cmp_q;
  assign cnt_d   = wr_cnt_s   ? Entrada_Datos    : cnt_seq_s;
  assign irq_d   = flag_q & ie_q;

`ifdef TIMER_PWM_EN
  logic inv_q;
  logic inv_d;

  assign inv_d = wr_ctrl_s ? Entrada_Datos[3] : inv_q;
  assign inv_s = inv_q;
  assign pwm_d = (running_s & (cnt_q < cmp_q)) ^ inv_q;

  // PWM polarity register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end
`else
  assign inv_s = 1'b0;
  assign pwm_d = 1'b0;
`endif

  // Read mux; zero when unselected or writing so the bus can be ORed with RAM.
  always_comb begin
    dout_d = 8'd0;
    if (sel_s && !RW) begin
      case (off_s)
        2'd0:    dout_d = ctrl_rd_s;
        2'd1:    dout_d = presc_q;
        2'd2:    dout_d = cmp_q;
        2'd3:    dout_d = cnt_q;
        default: dout_d = 8'd0;
      endcase
    end else begin
      dout_d = 8'd0;
    end
  end

  // State and register file.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      flag_q  <= 1'b0;
      presc_q <= PRESC_RESET;
      cmp_q   <= 8'hFF;
      cnt_q   <= 8'd0;
      pre_q   <= 8'd0;
      dout_q  <= 8'd0;
      irq_q   <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      flag_q  <= flag_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
      pwm_q   <= pwm_d;
    end
  end

  assign Datos_Salida = dout_q;
  assign Irq          = irq_q;
  assign Pwm          = pwm_q;

endmodule
